memory_access_stage: RTL and testbench

- Pipeline MEM stage of the RISC-V core, between execute and writeback.
- Consumes the execute-stage ALU result plus resultSrc/truncSrc control; issues data-memory loads/stores over a valid/ready request channel with separate response.
- Aligns store data with byte enables; extracts and sign/zero-extends load data.
- Stalls upstream while a memory transaction is outstanding.

---
 rtl/memory_access_stage_pkg.sv | 68 ++++++
 rtl/memory_access_stage_load_align.sv | 40 ++++
 rtl/memory_access_stage.sv | 201 ++++++++++++++++++++
 tb/tb_memory_access_stage.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//
// Holds the result-source and truncation encodings used by the execute stage.
// It also holds the MEM-stage state constants and the helpers that turn a
// truncation code and byte offset into an access size and a byte-lane mask.
package memory_access_stage_pkg;

  localparam int BYTE_LANES = 4;

  // resultSrc: where the writeback value comes from
  typedef enum logic {
    RESULT_ALU = 1'b0,
    RESULT_MEM = 1'b1
  } result_src_t;

  // truncSrc: access width and signedness of a memory access
  typedef enum logic [2:0] {
    TRUNC_NONE               = 3'd0,
    TRUNC_BYTE               = 3'd1,
    TRUNC_HALF_WORD          = 3'd2,
    TRUNC_WORD               = 3'd3,
    TRUNC_BYTE_UNSIGNED      = 3'd4,
    TRUNC_HALF_WORD_UNSIGNED = 3'd5
  } trunc_src_t;

  // memStageState, kept as plain constants so older tools that lack enum
  // support can still read the state register
  typedef logic [1:0] mem_stage_state_t;
  localparam mem_stage_state_t MEM_IDLE = 2'd0;
  localparam mem_stage_state_t MEM_REQ  = 2'd1;
  localparam mem_stage_state_t MEM_WAIT = 2'd2;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } access_size_t;

  // NONE and any unused code behave as a full word access.
  function automatic access_size_t access_size(input logic [2:0] trunc);
    case (trunc)
      TRUNC_BYTE, TRUNC_BYTE_UNSIGNED:           access_size = SIZE_BYTE;
      TRUNC_HALF_WORD, TRUNC_HALF_WORD_UNSIGNED: access_size = SIZE_HALF;
      default:                                   access_size = SIZE_WORD;
    endcase
  endfunction

  // A half is misaligned at odd offsets. A word is misaligned at any non-zero
  // offset.
  function automatic logic is_misaligned(input logic [2:0] trunc, input logic [1:0] offset);
    case (access_size(trunc))
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = offset[0];
      default:   is_misaligned = |offset;
    endcase
  endfunction

  // Low address bits below the access size are ignored. This aligns
  // misaligned accesses down to their natural boundary.
  function automatic logic [3:0] lane_mask(input logic [2:0] trunc, input logic [1:0] offset);
    case (access_size(trunc))
      SIZE_BYTE: lane_mask = 4'b0001 << offset;
      SIZE_HALF: lane_mask = 4'b0011 << {offset[1], 1'b0};
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_stage_load_align.sv
// load_align_extend: combinational load-data extraction.
//
// Selects the addressed byte or half-word from a full memory word. It then
// sign- or zero-extends that value according to the truncation code. A word
// access, or NONE, returns the word unchanged.
//
// Ports:
//   rdata   in  XLEN  word returned by data memory
//   offset  in  2     byte offset of the access (addr[1:0])
//   trunc   in  3     truncSrc code of the load
//   value   out XLEN  extended load result
module load_align_extend
  import memory_access_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      trunc,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // A half-word always comes from lanes 0-1 or 2-3. Because of this, only
  // offset[1] selects it, and an odd offset falls back to the aligned half.
  always_comb begin
    byte_val = rdata[{offset, 3'b000} +: 8];
    half_val = rdata[{offset[1], 4'b0000} +: 16];
    case (trunc)
      TRUNC_BYTE:               value = {{(XLEN-8){byte_val[7]}}, byte_val};
      TRUNC_BYTE_UNSIGNED:      value = {{(XLEN-8){1'b0}}, byte_val};
      TRUNC_HALF_WORD:          value = {{(XLEN-16){half_val[15]}}, half_val};
      TRUNC_HALF_WORD_UNSIGNED: value = {{(XLEN-16){1'b0}}, half_val};
      default:                  value = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: MEM pipeline stage between execute and writeback.
//
// Non-memory instructions pass their ALU result to writeback one cycle after
// they are accepted. Loads and stores issue one request on the data-memory
// valid/ready channel. A load then waits for dmem_resp_valid. While a
// transaction is outstanding, ex_ready is low.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to add wb_misaligned. With it,
// a misaligned access reports a fault instead of being silently aligned.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   ex_valid / ex_ready     instruction handshake from execute
//   ex_alu_result           ALU result or effective address
//   ex_store_data           rs2 value for stores
//   ex_mem_write            instruction is a store
//   ex_result_src           0 = ALU result, 1 = load
//   ex_trunc_src            access width and signedness
//   ex_rd, ex_reg_write     destination register and its write enable
//   dmem_req_valid/_ready   request handshake to data memory
//   dmem_addr/we/be/wdata   word address, write flag, byte enables, lane data
//   dmem_resp_valid/rdata   load response
//   wb_valid                one-cycle pulse carrying a result to writeback
//   wb_result, wb_rd        writeback value and destination register
//   wb_reg_write            register file write enable
//   wb_misaligned           fault flag (only with MEM_MISALIGN_TRAP_EN)
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic                  ex_mem_write,
  input  logic                  ex_result_src,
  input  logic [2:0]            ex_trunc_src,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [XLEN-1:0]       dmem_addr,
  output logic                  dmem_we,
  output logic [3:0]            dmem_be,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_resp_valid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  wb_valid,
  output logic [XLEN-1:0]       wb_result,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_reg_write
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  wb_misaligned
`endif
);

  mem_stage_state_t      state;
  logic                  accept;
  logic                  is_mem_op;
  logic [1:0]            offset;
  logic [3:0]            store_be;
  logic [XLEN-1:0]       store_wdata;
  logic [XLEN-1:0]       load_value;
  logic [REG_ADDR_W-1:0] cap_rd;
  logic                  cap_reg_write;
  logic [2:0]            cap_trunc;
  logic [1:0]            cap_offset;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                  misaligned;
`endif

  assign ex_ready  = (state == MEM_IDLE);
  assign accept    = ex_valid & ex_ready;
  assign is_mem_op = ex_mem_write | (ex_result_src == RESULT_MEM);
  assign offset    = ex_alu_result[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = is_mem_op & is_misaligned(ex_trunc_src, offset);
`endif

  // Store data is replicated across every lane of its width. Because of
  // this, memory only needs to honour dmem_be and never shift the data.
  always_comb begin
    store_be = lane_mask(ex_trunc_src, offset);
    case (access_size(ex_trunc_src))
      SIZE_BYTE: store_wdata = {BYTE_LANES{ex_store_data[7:0]}};
      SIZE_HALF: store_wdata = {(BYTE_LANES/2){ex_store_data[15:0]}};
      default:   store_wdata = ex_store_data;
    endcase
  end

  // The response word is decoded using the offset and truncation captured
  // when the load was accepted.
  load_align_extend #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata  (dmem_rdata),
    .offset (cap_offset),
    .trunc  (cap_trunc),
    .value  (load_value)
  );

  // Control FSM and output registers:
  //   IDLE -> REQ  when a load or store is accepted
  //   REQ  -> IDLE when a store handshakes
  //   REQ  -> WAIT when a load handshakes
  //   WAIT -> IDLE when the response arrives
  // dmem_resp_valid is looked at only in WAIT. A stray response in any other
  // state is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= MEM_IDLE;
      dmem_req_valid <= 1'b0;
      dmem_addr      <= '0;
      dmem_we        <= 1'b0;
      dmem_be        <= '0;
      dmem_wdata     <= '0;
      wb_valid       <= 1'b0;
      wb_result      <= '0;
      wb_rd          <= '0;
      wb_reg_write   <= 1'b0;
      cap_rd         <= '0;
      cap_reg_write  <= 1'b0;
      cap_trunc      <= '0;
      cap_offset     <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      wb_misaligned  <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      wb_misaligned <= 1'b0;
`endif
      case (state)
        MEM_IDLE: begin
          if (accept) begin
            cap_rd        <= ex_rd;
            cap_reg_write <= ex_reg_write;
            cap_trunc     <= ex_trunc_src;
            cap_offset    <= offset;
            if (!is_mem_op) begin
              wb_valid     <= 1'b1;
              wb_result    <= ex_alu_result;
              wb_rd        <= ex_rd;
              wb_reg_write <= ex_reg_write;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            else if (misaligned) begin
              wb_valid      <= 1'b1;
              wb_result     <= ex_alu_result;
              wb_rd         <= ex_rd;
              wb_reg_write  <= 1'b0;
              wb_misaligned <= 1'b1;
            end
`endif
            else begin
              state          <= MEM_REQ;
              dmem_req_valid <= 1'b1;
              dmem_addr      <= {ex_alu_result[XLEN-1:2], 2'b00};
              dmem_we        <= ex_mem_write;
              dmem_be        <= store_be;
              dmem_wdata     <= ex_mem_write ? store_wdata : '0;
            end
          end
        end
        MEM_REQ: begin
          if (dmem_req_valid && dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            if (dmem_we) begin
              wb_valid     <= 1'b1;
              wb_rd        <= cap_rd;
              wb_reg_write <= 1'b0;
              state        <= MEM_IDLE;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (dmem_resp_valid) begin
            wb_valid     <= 1'b1;
            wb_result    <= load_value;
            wb_rd        <= cap_rd;
            wb_reg_write <= cap_reg_write;
            state        <= MEM_IDLE;
          end
        end
        default: begin
          state          <= MEM_IDLE;
          dmem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Testbench for memory_access_stage. It runs directed cases followed by a
// randomized mix of ALU, load and store operations. Expected values come
// from a small arithmetic model of the byte-lane rules. Define
// MEM_MISALIGN_TRAP_EN to exercise the misalignment trap build.
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        ex_mem_write;
  logic        ex_result_src;
  logic [2:0]  ex_trunc_src;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_resp_valid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        wb_misaligned;
`endif

  int errors = 0;
  int checks = 0;

  memory_access_stage #(
    .XLEN       (32),
    .REG_ADDR_W (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_alu_result   (ex_alu_result),
    .ex_store_data   (ex_store_data),
    .ex_mem_write    (ex_mem_write),
    .ex_result_src   (ex_result_src),
    .ex_trunc_src    (ex_trunc_src),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_addr       (dmem_addr),
    .dmem_we         (dmem_we),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_rdata      (dmem_rdata),
    .wb_valid        (wb_valid),
    .wb_result       (wb_result),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .wb_misaligned   (wb_misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: access size in bytes
  function automatic int model_size(input logic [2:0] t);
    if (t == TRUNC_BYTE || t == TRUNC_BYTE_UNSIGNED) return 1;
    if (t == TRUNC_HALF_WORD || t == TRUNC_HALF_WORD_UNSIGNED) return 2;
    return 4;
  endfunction

  // Reference model: first byte lane actually touched
  function automatic int model_lane(input logic [31:0] addr, input logic [2:0] t);
    int sz;
    sz = model_size(t);
    return (int'(addr % 4) / sz) * sz;
  endfunction

  function automatic logic model_misaligned(input logic [31:0] addr, input logic [2:0] t);
    return (addr % model_size(t)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [2:0] t);
    int sz;
    int bits;
    sz   = model_size(t);
    bits = ((1 << sz) - 1) << model_lane(addr, t);
    return bits[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] t);
    case (model_size(t))
      1:       return (d & 32'h0000_00FF) * 32'h0101_0101;
      2:       return (d & 32'h0000_FFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] t);
    int          sz;
    logic [31:0] mask;
    logic [31:0] field;
    logic        is_signed;
    sz = model_size(t);
    if (sz == 4) return rdata;
    mask      = (32'd1 << (8 * sz)) - 32'd1;
    field     = (rdata >> (8 * model_lane(addr, t))) & mask;
    is_signed = (t == TRUNC_BYTE) || (t == TRUNC_HALF_WORD);
    if (is_signed && field >= (32'd1 << (8 * sz - 1))) field = field | ~mask;
    return field;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] sdata, input logic mw,
                               input logic rsrc, input logic [2:0] t, input logic [4:0] rd,
                               input logic rw);
    ex_valid      = 1'b1;
    ex_alu_result = alu;
    ex_store_data = sdata;
    ex_mem_write  = mw;
    ex_result_src = rsrc;
    ex_trunc_src  = t;
    ex_rd         = rd;
    ex_reg_write  = rw;
  endtask

  task automatic do_alu(input logic [31:0] alu, input logic [4:0] rd, input logic rw);
    applyStimulus(alu, $urandom, 1'b0, 1'b0, 3'($urandom_range(0, 5)), rd, rw);
    @(negedge clk);
    ex_valid = 1'b0;
    checkOutput("alu_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("alu_wb_result", wb_result, alu);
    checkOutput("alu_wb_rd", 32'(wb_rd), 32'(rd));
    checkOutput("alu_wb_reg_write", 32'(wb_reg_write), 32'(rw));
    checkOutput("alu_ex_ready", 32'(ex_ready), 32'd1);
    checkOutput("alu_no_req", 32'(dmem_req_valid), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    checkOutput("alu_misaligned", 32'(wb_misaligned), 32'd0);
`endif
  endtask

  // Drives the request phase. Stray responses are injected in REQ and must
  // be ignored.
  task automatic req_phase(input logic [31:0] addr, input logic we, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input int stall);
    for (int k = 0; k <= stall; k++) begin
      checkOutput("req_valid", 32'(dmem_req_valid), 32'd1);
      checkOutput("req_addr", dmem_addr, {addr[31:2], 2'b00});
      checkOutput("req_we", 32'(dmem_we), 32'(we));
      checkOutput("req_ex_ready", 32'(ex_ready), 32'd0);
      checkOutput("req_wb_valid", 32'(wb_valid), 32'd0);
      if (we) begin
        checkOutput("req_be", 32'(dmem_be), 32'(exp_be));
        checkOutput("req_wdata", dmem_wdata, exp_wdata);
      end
      dmem_resp_valid = 1'($urandom_range(0, 1));
      dmem_rdata      = $urandom;
      if (k == stall) begin
        dmem_req_ready  = 1'b1;
        dmem_resp_valid = 1'b0;
      end
      @(negedge clk);
    end
    dmem_req_ready = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] t,
                          input int stall, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    applyStimulus(addr, data, 1'b1, 1'b0, t, 5'($urandom_range(0, 31)), 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
    req_phase(addr, 1'b1, exp_be, exp_wdata, stall);
    checkOutput("st_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("st_wb_reg_write", 32'(wb_reg_write), 32'd0);
    checkOutput("st_req_dropped", 32'(dmem_req_valid), 32'd0);
    checkOutput("st_ex_ready", 32'(ex_ready), 32'd1);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] t, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic rw, input int stall, input int delay,
                         input logic [31:0] expected);
    applyStimulus(addr, $urandom, 1'b0, 1'b1, t, rd, rw);
    @(negedge clk);
    ex_valid = 1'b0;
    req_phase(addr, 1'b0, 4'b0000, 32'd0, stall);
    for (int d = 0; d < delay; d++) begin
      checkOutput("wait_wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("wait_ex_ready", 32'(ex_ready), 32'd0);
      @(negedge clk);
    end
    dmem_resp_valid = 1'b1;
    dmem_rdata      = rdata;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    dmem_rdata      = $urandom;
    checkOutput("ld_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("ld_wb_result", wb_result, expected);
    checkOutput("ld_wb_rd", 32'(wb_rd), 32'(rd));
    checkOutput("ld_wb_reg_write", 32'(wb_reg_write), 32'(rw));
    checkOutput("ld_ex_ready", 32'(ex_ready), 32'd1);
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic do_trap(input logic [31:0] addr, input logic mw, input logic [2:0] t);
    applyStimulus(addr, $urandom, mw, ~mw, t, 5'($urandom_range(0, 31)), 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
    checkOutput("trap_no_req", 32'(dmem_req_valid), 32'd0);
    checkOutput("trap_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("trap_misaligned", 32'(wb_misaligned), 32'd1);
    checkOutput("trap_wb_result", wb_result, addr);
    checkOutput("trap_wb_reg_write", 32'(wb_reg_write), 32'd0);
    checkOutput("trap_ex_ready", 32'(ex_ready), 32'd1);
  endtask
`endif

  initial begin
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  t;
    int          kind;

    reset           = 1'b1;
    ex_valid        = 1'b0;
    ex_alu_result   = '0;
    ex_store_data   = '0;
    ex_mem_write    = 1'b0;
    ex_result_src   = 1'b0;
    ex_trunc_src    = '0;
    ex_rd           = '0;
    ex_reg_write    = 1'b0;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_rdata      = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    checkOutput("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    checkOutput("rst_we", 32'(dmem_we), 32'd0);
    checkOutput("rst_wb_result", wb_result, 32'd0);
    checkOutput("rst_wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("rst_addr", dmem_addr, 32'd0);
    checkOutput("rst_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_be", 32'(dmem_be), 32'd0);
    checkOutput("rst_ex_ready", 32'(ex_ready), 32'd1);
`ifdef MEM_MISALIGN_TRAP_EN
    checkOutput("rst_misaligned", 32'(wb_misaligned), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // ALU op, then an idle cycle to confirm wb_valid is a single pulse
    do_alu(32'h0000_1234, 5'd5, 1'b1);
    @(negedge clk);
    checkOutput("wb_valid_pulse", 32'(wb_valid), 32'd0);

    // Back-to-back ALU ops, one per cycle
    for (int i = 0; i < 6; i++) do_alu($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

    // SB with two stall cycles
    do_store(32'h0000_1003, 32'h0000_00AB, TRUNC_BYTE, 2, 4'b1000, 32'hABAB_ABAB);
    do_store(32'h0000_1002, 32'h1234_5678, TRUNC_HALF_WORD, 0, 4'b1100, 32'h5678_5678);
    do_store(32'h0000_1000, 32'hDEAD_BEEF, TRUNC_WORD, 1, 4'b1111, 32'hDEAD_BEEF);

    // Directed loads
    do_load(32'h0000_2001, TRUNC_BYTE, 32'h0000_8000, 5'd7, 1'b1, 0, 0, 32'hFFFF_FF80);
    do_load(32'h0000_2001, TRUNC_BYTE_UNSIGNED, 32'h0000_8000, 5'd8, 1'b1, 1, 1, 32'h0000_0080);
    do_load(32'h0000_2002, TRUNC_HALF_WORD, 32'h8001_0000, 5'd9, 1'b1, 0, 2, 32'hFFFF_8001);
    do_load(32'h0000_2002, TRUNC_HALF_WORD_UNSIGNED, 32'h8001_0000, 5'd10, 1'b1, 0, 0, 32'h0000_8001);
    do_load(32'h0000_2000, TRUNC_WORD, 32'h8001_0000, 5'd11, 1'b1, 0, 0, 32'h8001_0000);
    do_load(32'h0000_2000, TRUNC_NONE, 32'hCAFE_F00D, 5'd12, 1'b0, 0, 0, 32'hCAFE_F00D);

    // Reset while in REQ drops the request at once
    applyStimulus(32'h0000_4000, 32'd0, 1'b0, 1'b1, TRUNC_WORD, 5'd3, 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
    checkOutput("rreq_valid_before", 32'(dmem_req_valid), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rreq_valid_dropped", 32'(dmem_req_valid), 32'd0);
    checkOutput("rreq_ex_ready", 32'(ex_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset while in WAIT, then a stale response after release
    applyStimulus(32'h0000_4004, 32'd0, 1'b0, 1'b1, TRUNC_WORD, 5'd4, 1'b1);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    checkOutput("rwait_in_wait", 32'(ex_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dmem_resp_valid = 1'b1;
    dmem_rdata      = 32'h1111_2222;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    checkOutput("rwait_no_wb", 32'(wb_valid), 32'd0);
    checkOutput("rwait_ex_ready", 32'(ex_ready), 32'd1);
    checkOutput("rwait_no_req", 32'(dmem_req_valid), 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    do_trap(32'h0000_3002, 1'b0, TRUNC_WORD);
    do_trap(32'h0000_3003, 1'b1, TRUNC_HALF_WORD);
`endif

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      addr = $urandom;
      data = $urandom;
      if (kind == 0) begin
        do_alu(addr, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end else begin
        if (kind == 1) t = 3'($urandom_range(0, 3));
        else t = 3'($urandom_range(0, 5));
`ifdef MEM_MISALIGN_TRAP_EN
        if (model_misaligned(addr, t)) begin
          do_trap(addr, kind == 1, t);
          continue;
        end
`endif
        if (kind == 1)
          do_store(addr, data, t, $urandom_range(0, 2), model_be(addr, t), model_wdata(data, t));
        else
          do_load(addr, t, data, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), $urandom_range(0, 2), model_load(data, addr, t));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
